// File: rtl/boa_div_iter.sv
// boa_div_iter: iterative radix-2 restoring divider with RISC-V M semantics.
// A 32-bit signed or unsigned divide takes 34 cycles. Valid/ready handshakes
// on input and output, abort flushes the operation in progress.
module boa_div_iter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        abort,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        u,
   input  logic [31:0] lhs,
   input  logic [31:0] rhs,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] div_res,
   output logic [31:0] mod_res
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t      state, state_nxt;
   logic        sign_lhs, sign_rhs;
   logic [31:0] mag_rhs;
   logic [31:0] rem, quo;
   logic [4:0]  count;

   // Operand decode for the accept cycle.
   logic        s_lhs, s_rhs;
   logic [31:0] m_lhs, m_rhs;
   logic        accept;

   assign s_lhs  = !u && lhs[31];
   assign s_rhs  = !u && rhs[31];
   assign m_lhs  = s_lhs ? -lhs : lhs;
   assign m_rhs  = s_rhs ? -rhs : rhs;
   assign accept = in_valid && (state == IDLE) && !abort;

   // One restoring step: shift {rem, quo} left and try subtracting |rhs|.
   // rem < |rhs| always holds, so the subtraction result fits in 32 bits.
   logic [32:0] rem_sh;
   logic        ge;
   logic [31:0] rem_sub;

   assign rem_sh  = {rem, quo[31]};
   assign ge      = rem_sh >= {1'b0, mag_rhs};
   assign rem_sub = rem_sh[31:0] - mag_rhs;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; abort overrides everything but reset.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = (rhs == 32'd0) ? DONE : CALC;
         CALC: if (count == 5'd31) state_nxt = FIX;
         FIX:  state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort) state_nxt = IDLE;
   end

   // Handshake outputs decoded from state.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Datapath: operand latch, shift/subtract iterations, sign fix-up.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sign_lhs <= 1'b0;
         sign_rhs <= 1'b0;
         mag_rhs  <= '0;
         rem      <= '0;
         quo      <= '0;
         count    <= '0;
         div_res  <= '0;
         mod_res  <= '0;
      end else if (!abort) begin
         case (state)
            IDLE: if (in_valid) begin
               sign_lhs <= s_lhs;
               sign_rhs <= s_rhs;
               mag_rhs  <= m_rhs;
               rem      <= '0;
               quo      <= m_lhs;
               count    <= '0;
               if (rhs == 32'd0) begin
                  // Divide by zero: all-ones quotient, raw dividend remainder.
                  div_res <= 32'hffff_ffff;
                  mod_res <= lhs;
               end
            end
            CALC: begin
               rem   <= ge ? rem_sub : rem_sh[31:0];
               quo   <= {quo[30:0], ge};
               count <= count + 5'd1;
            end
            FIX: begin
               div_res <= (sign_lhs ^ sign_rhs) ? -quo : quo;
               mod_res <= sign_lhs ? -rem : rem;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_boa_div_iter.sv
// Directed-vector bench for boa_div_iter: results, latency, output stall,
// divide by zero, overflow, abort and reset behaviour.
module tb_boa_div_iter;

   logic        clk = 1'b0;
   logic        rst_n, abort, in_valid, u, out_ready;
   logic [31:0] lhs, rhs;
   logic        in_ready, out_valid;
   logic [31:0] div_res, mod_res;

   int n_vec = 0;
   int n_err = 0;

   boa_div_iter dut (
      .clk(clk), .rst_n(rst_n), .abort(abort),
      .in_valid(in_valid), .in_ready(in_ready),
      .u(u), .lhs(lhs), .rhs(rhs),
      .out_valid(out_valid), .out_ready(out_ready),
      .div_res(div_res), .mod_res(mod_res)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one operation at a negedge and wait for out_valid.
   // Latency counts the accept edge as edge 1.
   task automatic issue(input logic uu, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
      @(negedge clk);
      in_valid = 1'b1; u = uu; lhs = a; rhs = b;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid = 1'b0;
      // Scramble operands; they must not affect the running operation.
      u = ~uu; lhs = 32'h5a5a_1234; rhs = 32'h0000_0003;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic run(input string tag, input logic uu, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                      input int elat);
      int lat;
      issue(uu, a, b, lat);
      chk({tag, "_lat"}, lat, elat);
      chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_q"}, div_res, eq);
      chk({tag, "_r"}, mod_res, er);
      take();
      chk({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
   endtask

   initial begin
      int lat;
      rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; u = 1'b0;
      out_ready = 1'b0; lhs = '0; rhs = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_hs", {30'd0, in_ready, out_valid}, 32'd2);
      chk("rst_q", div_res, 32'd0);
      chk("rst_r", mod_res, 32'd0);

      // Unsigned 100/7 with a 5-cycle output stall.
      issue(1'b1, 32'd100, 32'd7, lat);
      chk("u100_lat", lat, 34);
      for (int i = 0; i < 5; i++) begin
         chk("stall_vld", {31'd0, out_valid}, 32'd1);
         chk("stall_q", div_res, 32'd14);
         chk("stall_r", mod_res, 32'd2);
         @(negedge clk);
      end
      take();
      chk("u100_idle", {30'd0, in_ready, out_valid}, 32'd2);

      run("sm7d2",  1'b0, 32'hffff_fff9, 32'd2,        32'hffff_fffd, 32'hffff_ffff, 34);
      run("s7dm2",  1'b0, 32'd7,        32'hffff_fffe, 32'hffff_fffd, 32'd1,         34);
      run("sm8dm3", 1'b0, 32'hffff_fff8, 32'hffff_fffd, 32'd2,        32'hffff_fffe, 34);
      run("ubig",   1'b1, 32'hffff_ffff, 32'h10,       32'h0fff_ffff, 32'hf,         34);
      run("dz_s",   1'b0, 32'hffff_fffb, 32'd0,        32'hffff_ffff, 32'hffff_fffb, 1);
      run("dz_u",   1'b1, 32'hffff_fffb, 32'd0,        32'hffff_ffff, 32'hffff_fffb, 1);
      run("ovf",    1'b0, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 32'd0,        34);
      run("u_by1",  1'b1, 32'hffff_ffff, 32'd1,        32'hffff_ffff, 32'd0,         34);

      // Abort at count 10, then a clean 20/3.
      @(negedge clk);
      in_valid = 1'b1; u = 1'b0; lhs = 32'd1000; rhs = 32'd9;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_hs", {30'd0, in_ready, out_valid}, 32'd2);
      begin
         int seen = 0;
         repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
         end
         chk("abort_novld", seen, 0);
      end
      run("post_abort", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 34);

      // Abort during DONE discards the result.
      issue(1'b1, 32'd9, 32'd0, lat);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_done", {30'd0, in_ready, out_valid}, 32'd2);

      // Reset pulse mid-CALC.
      @(negedge clk);
      in_valid = 1'b1; u = 1'b1; lhs = 32'd50; rhs = 32'd5;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rcalc_hs", {30'd0, in_ready, out_valid}, 32'd2);
      chk("rcalc_q", div_res, 32'd0);
      chk("rcalc_r", mod_res, 32'd0);

      // Reset pulse during DONE.
      issue(1'b1, 32'd77, 32'd4, lat);
      chk("rdone_pre", div_res, 32'd19);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rdone_hs", {30'd0, in_ready, out_valid}, 32'd2);
      chk("rdone_q", div_res, 32'd0);
      chk("rdone_r", mod_res, 32'd0);

      // abort with in_valid in IDLE: nothing accepted (rhs=0 would show at once).
      @(negedge clk);
      abort = 1'b1; in_valid = 1'b1; u = 1'b1; lhs = 32'd4; rhs = 32'd0;
      @(negedge clk);
      abort = 1'b0; in_valid = 1'b0;
      chk("abt_inv_hs", {30'd0, in_ready, out_valid}, 32'd2);
      @(negedge clk);
      chk("abt_inv_vld", {31'd0, out_valid}, 32'd0);
      chk("abt_inv_q", div_res, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/boa_div_iter.md
# boa_div_iter

Iterative radix-2 restoring divider for the Boa³² M-extension path, replacing the zero-latency combinational divider where timing closure or area matters. It computes the 32-bit quotient and remainder of signed or unsigned operands over 34 cycles, using a valid/ready handshake on input and output so the pipeline's execute stage can stall on it. RISC-V M semantics apply exactly, including division by zero and signed overflow.

## Interface
- No parameters.
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- abort  input  1  cancel the operation in progress (pipeline flush).
- in_valid  input  1  operands valid.
- in_ready  output  1  divider idle, can accept operands.
- u  input  1  1 = unsigned (DIVU/REMU), 0 = signed (DIV/REM).
- lhs  input  32  dividend.
- rhs  input  32  divisor.
- out_valid  output  1  results valid.
- out_ready  input  1  consumer takes results.
- div_res  output  32  quotient.
- mod_res  output  32  remainder.

## Operation
- States: IDLE, CALC, FIX, DONE.
- in_ready = (state == IDLE). out_valid = (state == DONE).
- IDLE: on in_valid: latch sign_lhs = !u && lhs[31], sign_rhs = !u && rhs[31], magnitudes |lhs|, |rhs| (two's-complement negate when sign set).
  - rhs == 0: div_res = 32'hffff_ffff, mod_res = lhs (raw, unmodified) -> DONE.
  - Otherwise: remainder accumulator = 0, quotient register = |lhs|, count = 0 -> CALC.
- CALC, one bit per cycle: shift {rem, quo} left 1; trial = rem_shifted − |rhs| (33-bit); if non-negative, rem = trial and quo[0] = 1, else quo[0] = 0. count increments; after count 31 -> FIX.
- FIX: div_res = (sign_lhs ^ sign_rhs) ? −quo : quo; mod_res = sign_lhs ? −rem : rem -> DONE.
- DONE: outputs held stable until out_valid && out_ready, then -> IDLE.
- Signed overflow (lhs = 32'h8000_0000, rhs = 32'hffff_ffff, u = 0) needs no special case: it yields div_res = 32'h8000_0000, mod_res = 0.
- abort: in any state, next edge -> IDLE. A DONE result not yet taken is discarded. abort and in_valid in the same IDLE cycle: abort wins, nothing is accepted.
- rst_n low: takes priority over abort. Next edge forces IDLE from any state, including mid-CALC.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, div_res = 0, mod_res = 0, count = 0.
- Accept edge = rising edge with in_valid && in_ready.
- Normal latency: out_valid rises 34 edges after the accept edge (32 CALC + 1 FIX + transition).
- Divide-by-zero latency: out_valid rises 1 edge after the accept edge.
- Back-to-back operation is not supported in DONE. in_ready rises the edge after the output handshake, so minimum issue interval is 35 cycles normal and 2 cycles div-by-zero.
- Inputs u/lhs/rhs are sampled only on the accept edge; later changes have no effect.
- div_res/mod_res hold the last result in IDLE; they are meaningful only while out_valid = 1.

## Test plan
- Unsigned: u = 1, lhs = 100, rhs = 7 -> after 34 edges, div_res = 14, mod_res = 2; out_ready held low 5 cycles -> outputs stable, then IDLE.
- Signed mixed signs: u = 0, lhs = −7 (32'hffff_fff9), rhs = 2 -> div_res = −3 (32'hffff_fffd), mod_res = −1 (32'hffff_ffff). Repeat with lhs = 7, rhs = −2 -> −3, 1.
- Divide by zero: u = 0, lhs = −5, rhs = 0 -> one edge later div_res = 32'hffff_ffff, mod_res = 32'hffff_fffb. Same with u = 1.
- Overflow: u = 0, lhs = 32'h8000_0000, rhs = 32'hffff_ffff -> div_res = 32'h8000_0000, mod_res = 0. Also u = 1, lhs = 32'hffff_ffff, rhs = 1 -> 32'hffff_ffff, 0.
- abort at count 10 of CALC -> IDLE next edge, in_ready = 1, out_valid never asserted. New operation 20/3 then gives 6, 2 with no residue from the aborted one.
- rst_n low for one cycle during CALC, and separately during DONE -> all outputs at reset values next edge. abort + in_valid together in IDLE -> no accept.
